// File: rtl/otl_axil_mem_bridge.sv
// otl_axil_mem_bridge: AXI4-Lite slave bridged onto a single-port memory request port
// Ports: s_axi_* AXI4-Lite slave (AW/W/B/AR/R), m_req_* shared memory request
// (read or write, held until m_req_ready), m_rsp_* read data return (no backpressure).
// Out-of-window accesses answer DECERR without touching memory.
module otl_axil_mem_bridge #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int MEM_AW = 10,
  parameter logic [ADDRW-1:0] BASE_ADDR = '0
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  input  logic [ADDRW-1:0]     s_axi_awaddr,
  input  logic [2:0]           s_axi_awprot,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATAW-1:0]     s_axi_wdata,
  input  logic [DATAW/8-1:0]   s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDRW-1:0]     s_axi_araddr,
  input  logic [2:0]           s_axi_arprot,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [DATAW-1:0]     s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 m_req_valid,
  input  logic                 m_req_ready,
  output logic                 m_req_we,
  output logic [MEM_AW-1:0]    m_req_addr,
  output logic [DATAW-1:0]     m_req_wdata,
  output logic [DATAW/8-1:0]   m_req_wstrb,
  input  logic                 m_rsp_valid,
  input  logic [DATAW-1:0]     m_rsp_rdata
);
  localparam int SW = DATAW / 8;
  localparam int OFS = $clog2(SW);
  localparam int WB = MEM_AW + OFS;
  typedef enum logic [1:0] {W_COLLECT, W_REQ, W_RESP} ws_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rs_t;
  ws_t ws_q, ws_d;
  rs_t rs_q, rs_d;
  logic aw_held_q, w_held_q, prio_q, lock_q, gnt_rd_q;
  logic [ADDRW-1:0] awaddr_q, araddr_q;
  logic [DATAW-1:0] wdata_q, rdata_q;
  logic [SW-1:0] wstrb_q;
  logic [1:0] bresp_q, rresp_q;
  logic rst, aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_pend, rd_pend, gnt_rd, acc, wr_acc, rd_acc;
  logic [ADDRW-1:0] waddr;
  logic unused;
  function automatic logic in_win(input logic [ADDRW-1:0] a);
    return (a >> WB) == (BASE_ADDR >> WB);
  endfunction
  assign rst = s_axi_areset;
  assign unused = ^{s_axi_awprot, s_axi_arprot, awaddr_q, araddr_q};
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign b_hs = s_axi_bvalid & s_axi_bready;
  assign r_hs = s_axi_rvalid & s_axi_rready;
  assign waddr = aw_held_q ? awaddr_q : s_axi_awaddr;
  assign wr_pend = ws_q == W_REQ;
  assign rd_pend = rs_q == R_REQ;
  // a stalled request keeps its grant; otherwise the priority owner wins a tie
  assign gnt_rd = lock_q ? gnt_rd_q : rd_pend & (~wr_pend | prio_q);
  assign acc = m_req_valid & m_req_ready;
  assign wr_acc = acc & ~gnt_rd;
  assign rd_acc = acc & gnt_rd;
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      ws_q <= W_COLLECT;
      rs_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      bresp_q <= 2'b00;
      rresp_q <= 2'b00;
      prio_q <= 1'b0;
      lock_q <= 1'b0;
      gnt_rd_q <= 1'b0;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      if (aw_hs) begin
        awaddr_q <= s_axi_awaddr;
        aw_held_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
        w_held_q <= 1'b1;
      end
      if (b_hs) begin
        aw_held_q <= 1'b0;
        w_held_q <= 1'b0;
      end
      if (ws_q == W_COLLECT && ws_d == W_RESP) bresp_q <= 2'b11;
      if (wr_acc) bresp_q <= 2'b00;
      if (ar_hs) araddr_q <= s_axi_araddr;
      if (ar_hs && rs_d == R_RESP) begin
        rresp_q <= 2'b11;
        rdata_q <= '0;
      end
      if (rs_q == R_WAIT && m_rsp_valid) begin
        rdata_q <= m_rsp_rdata;
        rresp_q <= 2'b00;
      end
      lock_q <= m_req_valid & ~m_req_ready;
      gnt_rd_q <= gnt_rd;
      // flip only on a fresh tie, not while a stalled request is held
      if (~lock_q & wr_pend & rd_pend) prio_q <= ~prio_q;
    end
  end
  always_comb begin
    ws_d = ws_q;
    if (ws_q == W_COLLECT && (aw_held_q | aw_hs) && (w_held_q | w_hs)) ws_d = in_win(waddr) ? W_REQ : W_RESP;
    else if (ws_q == W_REQ && wr_acc) ws_d = W_RESP;
    else if (ws_q == W_RESP && b_hs) ws_d = W_COLLECT;
  end
  always_comb begin
    rs_d = rs_q;
    if (rs_q == R_IDLE && ar_hs) rs_d = in_win(s_axi_araddr) ? R_REQ : R_RESP;
    else if (rs_q == R_REQ && rd_acc) rs_d = R_WAIT;
    else if (rs_q == R_WAIT && m_rsp_valid) rs_d = R_RESP;
    else if (rs_q == R_RESP && r_hs) rs_d = R_IDLE;
  end
  always_comb begin
    s_axi_awready = ~rst & (ws_q == W_COLLECT) & ~aw_held_q;
    s_axi_wready = ~rst & (ws_q == W_COLLECT) & ~w_held_q;
    s_axi_bvalid = ~rst & (ws_q == W_RESP);
    s_axi_bresp = s_axi_bvalid ? bresp_q : 2'b00;
    s_axi_arready = ~rst & (rs_q == R_IDLE);
    s_axi_rvalid = ~rst & (rs_q == R_RESP);
    s_axi_rresp = s_axi_rvalid ? rresp_q : 2'b00;
    s_axi_rdata = s_axi_rvalid ? rdata_q : '0;
    m_req_valid = ~rst & (wr_pend | rd_pend);
    m_req_we = m_req_valid & ~gnt_rd;
    m_req_addr = ~m_req_valid ? '0 : gnt_rd ? araddr_q[WB-1:OFS] : awaddr_q[WB-1:OFS];
    m_req_wdata = m_req_we ? wdata_q : '0;
    m_req_wstrb = m_req_we ? wstrb_q : '0;
  end
endmodule

// File: tb/tb_otl_axil_mem_bridge.sv
// tb_otl_axil_mem_bridge: directed scoreboard bench for otl_axil_mem_bridge
module tb_otl_axil_mem_bridge;
  logic clk = 1'b0, rst;
  logic [31:0] awaddr, wdata, araddr, rdata, mwdata, rsp_data;
  logic [3:0] wstrb, mwstrb;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic mvalid, mready, mwe, rsp_valid;
  logic [9:0] maddr;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic we; logic [9:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} r_t;
  req_t exp_req[$];
  logic [1:0] exp_b[$];
  r_t exp_r[$];
  otl_axil_mem_bridge dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .m_req_valid(mvalid), .m_req_ready(mready), .m_req_we(mwe), .m_req_addr(maddr),
    .m_req_wdata(mwdata), .m_req_wstrb(mwstrb), .m_rsp_valid(rsp_valid), .m_rsp_rdata(rsp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (mvalid && mready) begin
        if (exp_req.size() == 0) chk("unexpected_mem_req", 1, 0);
        else begin
          req_t e;
          e = exp_req.pop_front();
          chk("req_we", mwe, e.we);
          chk("req_addr", maddr, e.addr);
          if (e.we) begin
            chk("req_wdata", mwdata, e.wdata);
            chk("req_wstrb", mwstrb, e.wstrb);
          end
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("unexpected_b", 1, 0);
        else chk("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("unexpected_r", 1, 0);
        else begin
          r_t e;
          e = exp_r.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
        end
      end
    end
  end
  initial begin
    rst = 1; awaddr = 0; wdata = 0; araddr = 0; wstrb = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; mready = 1; rsp_valid = 0; rsp_data = 0;
    tick(3);
    chk("rst_outputs", {awready, wready, arready, bvalid, rvalid, mvalid, bresp, rresp}, 0);
    rst = 0;
    tick();
    chk("readies_after_rst", {awready, wready, arready}, 3'b111);
    // AW and W together, in window
    exp_req.push_back('{1'b1, 10'd4, 32'hA5A5A5A5, 4'hF});
    exp_b.push_back(2'b00);
    awaddr = 32'h10; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("w1_cycle1_req", {mvalid, mwe, maddr, mwstrb}, {1'b1, 1'b1, 10'd4, 4'hF});
    tick();
    chk("w1_cycle2_b", {bvalid, bresp}, {1'b1, 2'b00});
    tick(2);
    // W three cycles ahead of AW
    exp_req.push_back('{1'b1, 10'd2, 32'h11223344, 4'h3});
    exp_b.push_back(2'b00);
    wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1;
    tick();
    wvalid = 0;
    chk("w2_wready_drop", {wready, awready}, 2'b01);
    tick(2);
    chk("w2_no_req_yet", mvalid, 0);
    awaddr = 32'h8; awvalid = 1;
    tick();
    awvalid = 0;
    chk("w2_req", {mvalid, maddr}, {1'b1, 10'd2});
    tick(3);
    // read with slow memory and slow rready
    exp_req.push_back('{1'b0, 10'h10, 32'h0, 4'h0});
    exp_r.push_back('{32'h12345678, 2'b00});
    rready = 0; araddr = 32'h40; arvalid = 1;
    tick();
    arvalid = 0;
    chk("r1_req", {mvalid, mwe, maddr, arready}, {1'b1, 1'b0, 10'h10, 1'b0});
    tick(3);
    rsp_valid = 1; rsp_data = 32'h12345678;
    tick();
    rsp_valid = 0; rsp_data = 0;
    for (int i = 0; i < 4; i++) begin
      chk("r1_hold", {rvalid, rdata, rresp, arready}, {1'b1, 32'h12345678, 2'b00, 1'b0});
      tick();
    end
    rready = 1;
    tick();
    chk("r1_done", {rvalid, arready}, 2'b01);
    // out-of-window write and read
    exp_b.push_back(2'b11);
    exp_r.push_back('{32'h0, 2'b11});
    awaddr = 32'h1000; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h2000; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("oow_resp", {bvalid, bresp, rvalid, rresp, rdata, mvalid}, {1'b1, 2'b11, 1'b1, 2'b11, 32'h0, 1'b0});
    tick();
    chk("oow_no_req", mvalid, 0);
    tick();
    // contention: write wins first, held while stalled
    exp_req.push_back('{1'b1, 10'd8, 32'hDEADBEEF, 4'hF});
    exp_req.push_back('{1'b0, 10'hC, 32'h0, 4'h0});
    exp_b.push_back(2'b00);
    exp_r.push_back('{32'hCAFEF00D, 2'b00});
    mready = 0;
    awaddr = 32'h20; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h30; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("arb1_hold", {mvalid, mwe, maddr, mwdata, mwstrb}, {1'b1, 1'b1, 10'd8, 32'hDEADBEEF, 4'hF});
      tick();
    end
    mready = 1;
    tick();
    chk("arb1_read_next", {mvalid, mwe, maddr}, {1'b1, 1'b0, 10'hC});
    tick();
    rsp_valid = 1; rsp_data = 32'hCAFEF00D;
    tick();
    rsp_valid = 0; rsp_data = 0;
    tick(2);
    // next contention: read wins
    exp_req.push_back('{1'b0, 10'hD, 32'h0, 4'h0});
    exp_req.push_back('{1'b1, 10'd9, 32'h01020304, 4'hF});
    exp_b.push_back(2'b00);
    exp_r.push_back('{32'h55AA55AA, 2'b00});
    mready = 0;
    awaddr = 32'h24; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h34; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("arb2_read_first", {mvalid, mwe, maddr}, {1'b1, 1'b0, 10'hD});
    mready = 1;
    tick();
    chk("arb2_write_next", {mvalid, mwe, maddr}, {1'b1, 1'b1, 10'd9});
    rsp_valid = 1; rsp_data = 32'h55AA55AA;
    tick();
    rsp_valid = 0; rsp_data = 0;
    tick(3);
    // reset while the read waits for memory
    exp_req.push_back('{1'b0, 10'h11, 32'h0, 4'h0});
    araddr = 32'h44; arvalid = 1;
    tick();
    arvalid = 0;
    tick();
    rst = 1;
    tick();
    chk("rst_mid_outputs", {awready, wready, arready, bvalid, rvalid, mvalid, rdata, rresp, bresp}, 0);
    rst = 0;
    tick();
    rsp_valid = 1; rsp_data = 32'hBAD0BAD0;
    tick();
    rsp_valid = 0; rsp_data = 0;
    tick(2);
    chk("rst_no_r", {rvalid, arready}, 2'b01);
    exp_req.push_back('{1'b0, 10'h12, 32'h0, 4'h0});
    exp_r.push_back('{32'h87654321, 2'b00});
    araddr = 32'h48; arvalid = 1;
    tick();
    arvalid = 0;
    tick();
    rsp_valid = 1; rsp_data = 32'h87654321;
    tick();
    rsp_valid = 0; rsp_data = 0;
    tick(3);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
